sop2_dot_seq: RTL and testbench

- Job sequencer for one int_sop_2_dspchain datapath unit.
- Accepts a stream of operand beats (ax, ay, bx, by) with a last flag and issues one beat per cycle to the datapath.
- Tracks in-flight beats with a tag pipeline matched to the datapath latency, accumulates each returned resulta, and presents the job's dot product on a valid/ready output.
- Sits between the operand-fetch stage and result writeback. Datapath chainin is held at 0.

---
 rtl/sop2_dot_seq_pkg.sv | 42 ++++
 rtl/sop2_dot_seq_if.sv | 58 +++++
 rtl/sop2_dot_seq_tag_pipe.sv | 33 +++
 rtl/sop2_dot_seq.sv | 137 +++++++++++++
 tb/tb_sop2_dot_seq.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sop2_dot_seq_pkg.sv
// Shared types and widths for the sop2 dot-product job sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sop2_seq_pkg;

  // Datapath operand / result widths as seen on the int_sop_2_dspchain unit.
  localparam int OPA_W       = 18;
  localparam int OPB_W       = 19;
  localparam int RES_W       = 37;
  localparam int MODE_W      = 11;

  // Clock edges from a change on the datapath inputs to the matching result.
  localparam int DSP_LAT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One tag rides alongside every issued beat so results can be matched
  // to beats without looking at the datapath itself.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // Operand beat as issued to the datapath.
  typedef struct packed {
    logic [OPA_W-1:0] ax;
    logic [OPB_W-1:0] ay;
    logic [OPA_W-1:0] bx;
    logic [OPB_W-1:0] by;
  } beat_t;

  // True in the states that take new operand beats.
  function automatic logic takes_beats(state_e s);
    return (s == IDLE) || (s == RUN);
  endfunction

endpackage

// File: rtl/sop2_dot_seq_if.sv
// Bundles the operand stream, datapath link and result stream of the sequencer.
// Latency: none (wiring only).
// Backpressure: s_ready / m_ready carried as plain signals; slave is the sequencer side.
interface sop2_dot_seq_if #(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
);

  // Job configuration
  logic [sop2_seq_pkg::MODE_W-1:0] cfg_mode;

  // Operand beat stream into the sequencer
  logic                            s_valid;
  logic                            s_ready;
  logic                            s_last;
  logic [sop2_seq_pkg::OPA_W-1:0]  s_ax;
  logic [sop2_seq_pkg::OPB_W-1:0]  s_ay;
  logic [sop2_seq_pkg::OPA_W-1:0]  s_bx;
  logic [sop2_seq_pkg::OPB_W-1:0]  s_by;

  // Link to the datapath unit
  logic [sop2_seq_pkg::MODE_W-1:0] dsp_mode_sigs;
  logic [sop2_seq_pkg::OPA_W-1:0]  dsp_ax;
  logic [sop2_seq_pkg::OPB_W-1:0]  dsp_ay;
  logic [sop2_seq_pkg::OPA_W-1:0]  dsp_bx;
  logic [sop2_seq_pkg::OPB_W-1:0]  dsp_by;
  logic [sop2_seq_pkg::RES_W-1:0]  dsp_chainin;
  logic [sop2_seq_pkg::RES_W-1:0]  dsp_resulta;

  // Job result stream out of the sequencer
  logic                            m_valid;
  logic                            m_ready;
  logic [ACC_W-1:0]                m_data;
  logic [CNT_W-1:0]                m_count;

  // Sequencer side
  modport slave (
    input  cfg_mode,
    input  s_valid, s_last, s_ax, s_ay, s_bx, s_by,
    output s_ready,
    output dsp_mode_sigs, dsp_ax, dsp_ay, dsp_bx, dsp_by, dsp_chainin,
    input  dsp_resulta,
    output m_valid, m_data, m_count,
    input  m_ready
  );

  // Environment side: operand fetch, datapath and writeback
  modport master (
    output cfg_mode,
    output s_valid, s_last, s_ax, s_ay, s_bx, s_by,
    input  s_ready,
    input  dsp_mode_sigs, dsp_ax, dsp_ay, dsp_bx, dsp_by, dsp_chainin,
    output dsp_resulta,
    input  m_valid, m_data, m_count,
    output m_ready
  );

endinterface

// File: rtl/sop2_dot_seq_tag_pipe.sv
// Shift register of {valid, last} tags tracking beats in flight through the datapath.
// Latency: DEPTH edges from tag_in to tag_out.
// Backpressure: none; shifts every cycle, the datapath cannot stall.
module sop2_tag_pipe
  import sop2_seq_pkg::*;
#(
  parameter int DEPTH = DSP_LAT_DEF + 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_q [DEPTH];

  // Advance every tag one stage per clock; reset drops all in-flight tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/sop2_dot_seq.sv
// Job sequencer: issues operand beats to one sop2 datapath and sums the returned results.
// Latency: m_valid rises DSP_LAT+1 edges after the last beat of a job is accepted.
// Backpressure: s_ready low from the last beat until the result handshake; m_valid holds until m_ready.
module sop2_dot_seq
  import sop2_seq_pkg::*;
#(
  parameter int DSP_LAT = DSP_LAT_DEF,
  parameter int ACC_W   = 48,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          reset,
  sop2_dot_seq_if.slave bus
);

  state_e            state_q;
  state_e            state_d;
  logic              st_done;
  logic              s_rdy;
  logic              accept;
  logic              res_ack;
  tag_t              tag_in;
  tag_t              tag_out;
  beat_t             beat_in;
  beat_t             beat_q;
  logic [MODE_W-1:0] mode_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;

  // Readiness is gated by reset so nothing looks accepted while reset is held.
  assign s_rdy   = takes_beats(state_q) & ~reset;
  assign accept  = bus.s_valid & s_rdy;
  assign res_ack = st_done & bus.m_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded result valid.
  always_comb begin
    state_d = state_q;
    st_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          state_d = bus.s_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (bus.s_valid && bus.s_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last-tagged result is folded into the accumulator on this edge.
        if (tag_out.valid && tag_out.last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        st_done = 1'b1;
        if (bus.m_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign beat_in = {bus.s_ax, bus.s_ay, bus.s_bx, bus.s_by};

  // Issue register: present the accepted beat for one cycle, zeros otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= '0;
      mode_q <= '0;
    end else begin
      beat_q <= accept ? beat_in : '0;
      // Mode is a per-job setting, captured only with the job's first beat.
      if (accept && (state_q == IDLE)) begin
        mode_q <= bus.cfg_mode;
      end
    end
  end

  assign bus.dsp_mode_sigs = mode_q;
  assign bus.dsp_ax        = beat_q.ax;
  assign bus.dsp_ay        = beat_q.ay;
  assign bus.dsp_bx        = beat_q.bx;
  assign bus.dsp_by        = beat_q.by;
  assign bus.dsp_chainin   = '0;

  // Tag enters at the issue edge; one extra stage covers the issue register
  // so the tag emerges exactly when dsp_resulta holds that beat's result.
  assign tag_in = {accept, accept & bus.s_last};

  sop2_tag_pipe #(
    .DEPTH (DSP_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Accumulate tagged results and count accepted beats; clear on result handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (res_ack) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      // Untagged datapath outputs (bubbles, results orphaned by reset) are ignored.
      if (tag_out.valid) begin
        acc_q <= acc_q + ACC_W'(bus.dsp_resulta);
      end
      if (accept) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.s_ready = s_rdy;
  assign bus.m_valid = st_done;
  assign bus.m_data  = acc_q;
  assign bus.m_count = cnt_q;

endmodule

// File: tb/tb_sop2_dot_seq.sv
// Scoreboard bench for sop2_dot_seq with a behavioural datapath model.
// Latency: checks DSP_LAT+1 edges from last accepted beat to m_valid.
// Backpressure: holds m_ready low in DONE and checks the held result.
module tb_sop2_dot_seq;
  import sop2_seq_pkg::*;

  localparam int DSP_LAT = 3;
  localparam int ACC_W   = 48;
  localparam int CNT_W   = 16;
  localparam logic [63:0] RES_MASK = (64'd1 << RES_W) - 64'd1;
  localparam logic [63:0] ACC_MASK = (64'd1 << ACC_W) - 64'd1;
  localparam logic [63:0] CNT_MASK = (64'd1 << CNT_W) - 64'd1;

  typedef struct {
    logic [OPA_W-1:0] ax;
    logic [OPB_W-1:0] ay;
    logic [OPA_W-1:0] bx;
    logic [OPB_W-1:0] by;
    int               gap;
  } tb_beat_t;

  typedef struct {
    logic [63:0] data;
    logic [63:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  tb_beat_t job[$];
  exp_t     exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sop2_dot_seq_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  sop2_dot_seq #(
    .DSP_LAT (DSP_LAT),
    .ACC_W   (ACC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Sum of two unsigned products, wrapped to the datapath result width.
  function automatic logic [63:0] sop_val(input logic [OPA_W-1:0] ax, input logic [OPB_W-1:0] ay,
                                          input logic [OPA_W-1:0] bx, input logic [OPB_W-1:0] by);
    logic [63:0] p;
    p = 64'(ax) * 64'(ay) + 64'(bx) * 64'(by);
    return p & RES_MASK;
  endfunction

  // Datapath model: result appears DSP_LAT edges after its operands; never reset.
  logic [RES_W-1:0] dp_pipe [DSP_LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= RES_W'((sop_val(bus.dsp_ax, bus.dsp_ay, bus.dsp_bx, bus.dsp_by)
                          + 64'(bus.dsp_chainin)) & RES_MASK);
    for (int i = 1; i < DSP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign bus.dsp_resulta = dp_pipe[DSP_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_beat(input logic [OPA_W-1:0] ax, input logic [OPB_W-1:0] ay,
                          input logic [OPA_W-1:0] bx, input logic [OPB_W-1:0] by, input int gap);
    tb_beat_t b;
    b.ax = ax; b.ay = ay; b.bx = bx; b.by = by; b.gap = gap;
    job.push_back(b);
  endtask

  // Drive the queued job, push its expected result, then walk it through DONE.
  task automatic run_job(input logic [MODE_W-1:0] mode, input int hold,
                         output int first_edge, output int last_edge, output int mv_edge);
    exp_t        e;
    logic [63:0] sum;
    int          k;
    sum = 64'd0;
    foreach (job[i]) sum = (sum + sop_val(job[i].ax, job[i].ay, job[i].bx, job[i].by)) & ACC_MASK;
    e.data  = sum;
    e.count = 64'(job.size()) & CNT_MASK;
    exp_q.push_back(e);
    first_edge = 0;
    last_edge  = 0;
    for (int i = 0; i < job.size(); i++) begin
      for (int g = 0; g < job[i].gap; g++) begin
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
      end
      @(negedge clk);
      bus.s_valid  = 1'b1;
      bus.s_ax     = job[i].ax;
      bus.s_ay     = job[i].ay;
      bus.s_bx     = job[i].bx;
      bus.s_by     = job[i].by;
      bus.s_last   = (i == job.size() - 1);
      bus.cfg_mode = (i == 0) ? mode : MODE_W'($urandom);
      k = 0;
      while (!bus.s_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (k >= 50) check("beat_accept_timeout", 64'(bus.s_ready), 64'd1);
      if (i == 0) first_edge = cyc + 1;
      last_edge = cyc + 1;
      @(posedge clk);
      #1;
      check("issue_ax", 64'(bus.dsp_ax), 64'(job[i].ax));
      check("issue_by", 64'(bus.dsp_by), 64'(job[i].by));
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("mode_latched", 64'(bus.dsp_mode_sigs), 64'(mode));
    k = 0;
    while (!bus.m_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    mv_edge = cyc;
    check("m_valid_latency", 64'(mv_edge - last_edge), 64'(DSP_LAT + 1));
    check("issue_idle_zero", 64'(bus.dsp_ax) | 64'(bus.dsp_bx), 64'd0);
    for (int h = 0; h < hold; h++) @(negedge clk);
    check("done_valid", 64'(bus.m_valid), 64'd1);
    check("done_data", 64'(bus.m_data), e.data);
    check("done_count", 64'(bus.m_count), e.count);
    check("done_s_ready", 64'(bus.s_ready), 64'd0);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    check("ack_s_ready", 64'(bus.s_ready), 64'd1);
    check("ack_m_valid", 64'(bus.m_valid), 64'd0);
    check("ack_clear", 64'(bus.m_data) | 64'(bus.m_count), 64'd0);
    job.delete();
  endtask

  // Monitor: compare every result handshake against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got data %0d with no expected job", bus.m_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_m_data", 64'(bus.m_data), e.data);
          check("sb_m_count", 64'(bus.m_count), e.count);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, got %0d results pending expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f, l, mv, k, n;
    reset        = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
    bus.s_ax     = '0;
    bus.s_ay     = '0;
    bus.s_bx     = '0;
    bus.s_by     = '0;
    bus.cfg_mode = '0;
    bus.m_ready  = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_data", 64'(bus.m_data), 64'd0);
    check("rst_m_count", 64'(bus.m_count), 64'd0);
    check("rst_dsp_ops", 64'(bus.dsp_ax) | 64'(bus.dsp_ay) | 64'(bus.dsp_bx) | 64'(bus.dsp_by), 64'd0);
    check("rst_dsp_mode", 64'(bus.dsp_mode_sigs), 64'd0);
    check("rst_chainin", 64'(bus.dsp_chainin), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_s_ready", 64'(bus.s_ready), 64'd1);

    // Single beat 2*3+4*5 = 26
    add_beat(2, 3, 4, 5, 0);
    run_job(11'h5A5, 0, f, l, mv);
    check("single_latency", 64'(mv - f), 64'd4);

    // Three beats back to back = 127
    add_beat(1, 1, 1, 1, 0);
    add_beat(10, 10, 0, 0, 0);
    add_beat(3, 7, 2, 2, 0);
    run_job(11'h123, 0, f, l, mv);
    check("b2b_total_latency", 64'(mv - f), 64'(2 + DSP_LAT + 1));

    // Same beats with a 2-cycle bubble between first and second beat
    add_beat(1, 1, 1, 1, 0);
    add_beat(10, 10, 0, 0, 2);
    add_beat(3, 7, 2, 2, 0);
    run_job(11'h7FF, 0, f, l, mv);
    check("bubble_total_latency", 64'(mv - f), 64'(2 + 2 + DSP_LAT + 1));

    // Backpressure in DONE, then a fresh job must report only its own sum
    add_beat(5, 6, 7, 8, 0);
    add_beat(100, 200, 300, 400, 0);
    run_job(11'h001, 5, f, l, mv);
    add_beat(1, 2, 3, 4, 0);
    run_job(11'h002, 0, f, l, mv);

    // Max operands: datapath wraps at 37 bits -> 137437380610
    add_beat(18'h3FFFF, 19'h7FFFF, 18'h3FFFF, 19'h7FFFF, 0);
    run_job(11'h400, 1, f, l, mv);

    // Reset mid-RUN after two beats
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_last = 1'b0;
    bus.s_ax = 9; bus.s_ay = 9; bus.s_bx = 9; bus.s_by = 9; bus.cfg_mode = 11'h0AA;
    @(negedge clk);
    bus.s_ax = 8; bus.s_ay = 8; bus.s_bx = 8; bus.s_by = 8;
    @(negedge clk);
    bus.s_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_s_ready", 64'(bus.s_ready), 64'd0);
    check("midrst_m_valid", 64'(bus.m_valid), 64'd0);
    check("midrst_dsp_ops", 64'(bus.dsp_ax) | 64'(bus.dsp_ay) | 64'(bus.dsp_bx) | 64'(bus.dsp_by), 64'd0);
    check("midrst_dsp_mode", 64'(bus.dsp_mode_sigs), 64'd0);
    check("midrst_acc", 64'(bus.m_data) | 64'(bus.m_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    add_beat(2, 3, 4, 5, 0);
    run_job(11'h155, 0, f, l, mv);

    // m_ready while m_valid is low has no effect
    @(negedge clk);
    bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("early_ready_m_valid", 64'(bus.m_valid), 64'd0);
    check("early_ready_s_ready", 64'(bus.s_ready), 64'd1);
    bus.m_ready = 1'b0;

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        if ($urandom_range(0, 7) == 0)
          add_beat(18'h3FFFF, 19'h7FFFF, 18'h3FFFF, 19'h7FFFF, 0);
        else
          add_beat(OPA_W'($urandom), OPB_W'($urandom), OPA_W'($urandom), OPB_W'($urandom),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      run_job(MODE_W'($urandom), $urandom_range(0, 3), f, l, mv);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
